// File: rtl/fxp_pkg.sv
// Shared constants, state type and width helper for the Q3.2 fixed-point accumulating stages.
package fxp_pkg;

  localparam int unsigned FRAC_BITS = 2;
  localparam int unsigned SUM_W     = 5;
  localparam logic [SUM_W-1:0] MEAN_MAX = 5'd31;

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } fxp_state_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    int unsigned x;
    r = 0;
    x = 1;
    while (x < v) begin
      x = x << 1;
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/fixed_point_sum_accumulator_if.sv
// Sample-in / result-out handshake bundle of the fixed-point sum accumulator.
interface fixed_point_sum_accumulator_if #(
  parameter int unsigned ACC_W = 8
);
  import fxp_pkg::*;

  logic [SUM_W-1:0] sum_in;
  logic             in_valid;
  logic             in_ready;
  logic [ACC_W-1:0] total;
  logic [SUM_W-1:0] mean;
  logic             sat;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output sum_in, in_valid, out_ready,
    input  in_ready, total, mean, sat, out_valid
  );

  modport slave (
    input  sum_in, in_valid, out_ready,
    output in_ready, total, mean, sat, out_valid
  );

endinterface

// File: rtl/fxp_sat_add.sv
// Unsigned ACC_W-bit + SUM_W-bit adder that saturates at all-ones and flags the overflow.
module fxp_sat_add
  import fxp_pkg::*;
#(
  parameter int unsigned ACC_W = 8
) (
  input  logic [ACC_W-1:0] acc_i,
  input  logic [SUM_W-1:0] add_i,
  output logic [ACC_W-1:0] sum_o,
  output logic             ovf_o
);

  logic [ACC_W:0] full;

  always_comb begin
    full  = {1'b0, acc_i} + (ACC_W + 1)'(add_i);
    ovf_o = full[ACC_W];
    sum_o = ovf_o ? '1 : full[ACC_W-1:0];
  end

endmodule

// File: rtl/fixed_point_sum_accumulator.sv
// Accumulates N_SAMPLES Q3.2 sums with saturation and presents the block total and mean
// on a held valid/ready output.
module fixed_point_sum_accumulator
  import fxp_pkg::*;
#(
  parameter int unsigned N_SAMPLES = 4,
  parameter int unsigned ACC_W     = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clear,
  fixed_point_sum_accumulator_if.slave bus
);

  localparam int unsigned ShiftW = clog2(N_SAMPLES);
  localparam int unsigned CntW   = ShiftW + 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(N_SAMPLES - 1);

  fxp_state_e       state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             sat_acc_q, sat_acc_d;
  logic             in_ready_q, in_ready_d;
  logic [ACC_W-1:0] total_q, total_d;
  logic [SUM_W-1:0] mean_q, mean_d;
  logic             sat_q, sat_d;

  logic [ACC_W-1:0] add_sum;
  logic             add_ovf;
  logic [ACC_W-1:0] mean_full;
  logic [SUM_W-1:0] mean_clamp;
  logic             accept;

  fxp_sat_add #(
    .ACC_W(ACC_W)
  ) u_sat_add (
    .acc_i(acc_q),
    .add_i(bus.sum_in),
    .sum_o(add_sum),
    .ovf_o(add_ovf)
  );

  always_comb begin
    mean_full  = add_sum >> ShiftW;
    mean_clamp = (mean_full > ACC_W'(MEAN_MAX)) ? MEAN_MAX : mean_full[SUM_W-1:0];
    accept     = bus.in_valid & in_ready_q & (state_q == ACCUM);
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    sat_acc_d = sat_acc_q;
    total_d   = total_q;
    mean_d    = mean_q;
    sat_d     = sat_q;

    if (clear) begin
      // Abort wins over everything, including a same-cycle sample or handshake.
      state_d   = ACCUM;
      acc_d     = '0;
      cnt_d     = '0;
      sat_acc_d = 1'b0;
      total_d   = '0;
      mean_d    = '0;
      sat_d     = 1'b0;
    end else begin
      unique case (state_q)
        ACCUM: begin
          if (accept) begin
            acc_d     = add_sum;
            cnt_d     = cnt_q + CntW'(1);
            sat_acc_d = sat_acc_q | add_ovf;
            if (cnt_q == LastCnt) begin
              total_d = add_sum;
              mean_d  = mean_clamp;
              sat_d   = sat_acc_q | add_ovf;
              state_d = HOLD;
            end
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            state_d   = ACCUM;
            acc_d     = '0;
            cnt_d     = '0;
            sat_acc_d = 1'b0;
            total_d   = '0;
            mean_d    = '0;
            sat_d     = 1'b0;
          end
        end
        default: state_d = ACCUM;
      endcase
    end

    in_ready_d = (state_d == ACCUM);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ACCUM;
      acc_q      <= '0;
      cnt_q      <= '0;
      sat_acc_q  <= 1'b0;
      in_ready_q <= 1'b0;
      total_q    <= '0;
      mean_q     <= '0;
      sat_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      sat_acc_q  <= sat_acc_d;
      in_ready_q <= in_ready_d;
      total_q    <= total_d;
      mean_q     <= mean_d;
      sat_q      <= sat_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = (state_q == HOLD);
  assign bus.total     = total_q;
  assign bus.mean      = mean_q;
  assign bus.sat       = sat_q;

endmodule
